// File: rtl/alu_issue.sv
// Issue/collect front end for the 4-bit ALU: latches a request, exposes it to the
// ALU for one cycle, captures result/flags and holds them until the consumer takes them.
module alu_issue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_use_acc,
    input  logic       acc_clr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_mod,
    input  logic [3:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_c,
    input  logic       alu_overflow,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_zero,
    output logic       out_c,
    output logic       out_ovf,
    output logic       out_illegal,
    output logic [3:0] acc,
    output logic       ovf_sticky,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t     state_q;
    logic       in_ready_q;
    logic [3:0] op_a_q;
    logic [3:0] op_b_q;
    logic [2:0] op_m_q;
    logic       out_valid_q;
    logic [3:0] res_q;
    logic       zero_q;
    logic       c_q;
    logic       ovf_q;
    logic       ill_q;
    logic [3:0] acc_q;
    logic       sticky_q;
    logic [7:0] count_q;

    logic [3:0] acc_d;
    logic [7:0] count_d;

    // A same-cycle clear is visible to an accumulator-sourced request.
    always_comb begin
        acc_d   = acc_clr ? 4'd0 : acc_q;
        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_m_q      <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            c_q         <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc_clr) begin
                        acc_q    <= 4'd0;
                        sticky_q <= 1'b0;
                    end
                    if (in_valid && in_ready_q) begin
                        op_a_q     <= in_use_acc ? acc_d : in_a;
                        op_b_q     <= in_b;
                        op_m_q     <= in_op;
                        in_ready_q <= 1'b0;
                        state_q    <= EXEC;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    res_q       <= alu_result;
                    zero_q      <= alu_zero;
                    c_q         <= alu_c;
                    ovf_q       <= alu_overflow;
                    ill_q       <= op_m_q[2];
                    acc_q       <= alu_result;
                    sticky_q    <= sticky_q | alu_overflow;
                    count_q     <= count_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_mod     = op_m_q;
    assign out_valid   = out_valid_q;
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_c       = c_q;
    assign out_ovf     = ovf_q;
    assign out_illegal = ill_q;
    assign acc         = acc_q;
    assign ovf_sticky  = sticky_q;
    assign op_count    = count_q;

endmodule
